dec_rr_arbiter: RTL

//  Round-robin arbiter sharing one 2-to-4 decoded select among four requesters.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/dec2to4.sv | 17 +
 rtl/dec_rr_arbiter.sv | 82 ++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types, sizes and the rotating-priority search for the round-robin arbiter.
package arb_pkg;

    localparam int NREQ         = 4;
    localparam int IDX_W        = 2;
    localparam int DEF_MAX_HOLD = 8;
    localparam int DEF_HOLD_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // First set request bit found when scanning upward from ptr, wrapping 3 -> 0.
    // Scans from the far end back toward ptr so the nearest hit is the last write.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/dec2to4.sv
// Combinational 2-to-4 one-hot decoder with enable; all zeros when disabled.
module dec2to4
    import arb_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [NREQ-1:0]  y
);

    // One-hot decode of idx, gated by en.
    always_comb begin
        // NOTE: default assignment first so no path leaves y unassigned (no latch).
        y = '0;
        if (en) y[idx] = 1'b1;
    end

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter for four requesters with bounded hold and a one-cycle
// gap between consecutive grants; the grant vector comes from a 2-to-4 decode
// of the registered winner index.
module dec_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HOLD_W   = DEF_HOLD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  winner;
    logic              others_wait;
    logic              release_now;

    assign winner      = rr_pick(req, ptr);
    assign others_wait = |(req & ~gnt);
    assign release_now = !req[gnt_idx] || ((hold_cnt >= HOLD_LAST) && others_wait);

    // gnt is decoded from registered index/valid only, so there is no req-to-gnt path
    // and an asynchronous reset of gnt_vld drops gnt without waiting for a clock.
    dec2to4 u_dec (
        .en  (gnt_vld),
        .idx (gnt_idx),
        .y   (gnt)
    );

    // Arbitration FSM: winner selection, grant hold/pre-emption, pointer rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every branch sees
        // the pre-edge values of gnt_idx, ptr and hold_cnt.
        if (!rst_n) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            gnt_vld  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (en && |req) begin
                        state    <= GRANT;
                        gnt_idx  <= winner;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        state   <= IDLE;
                        gnt_vld <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state    <= GAP;
                        gnt_vld  <= 1'b0;
                        ptr      <= gnt_idx + IDX_W'(1);
                        hold_cnt <= '0;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
